// File: rtl/rtc_bus_arbiter_if.sv
// Bus bundle for rtc_bus_arbiter: three requester channels, the result path
// back to the requesters, and the command/completion path to the RTC bus engine.
//   slave  : arbiter side. It drives gnt/ack/rdata/eng_*/busy/timeout_err.
//   master : environment side. It covers the requesters and the engine.
interface rtc_bus_arbiter_if;
  logic       req_init;
  logic       req_us;
  logic       req_rd;
  logic [7:0] addr_init;
  logic [7:0] addr_us;
  logic [7:0] addr_rd;
  logic [7:0] wdata_init;
  logic [7:0] wdata_us;
  logic [2:0] gnt;
  logic [2:0] ack;
  logic [7:0] rdata;
  logic       eng_start;
  logic [7:0] eng_addr;
  logic [7:0] eng_wdata;
  logic       eng_we;
  logic       eng_done;
  logic [7:0] eng_rdata;
  logic       busy;
  logic       timeout_err;

  modport slave (
    input  req_init, req_us, req_rd, addr_init, addr_us, addr_rd,
           wdata_init, wdata_us, eng_done, eng_rdata,
    output gnt, ack, rdata, eng_start, eng_addr, eng_wdata, eng_we,
           busy, timeout_err
  );

  modport master (
    output req_init, req_us, req_rd, addr_init, addr_us, addr_rd,
           wdata_init, wdata_us, eng_done, eng_rdata,
    input  gnt, ack, rdata, eng_start, eng_addr, eng_wdata, eng_we,
           busy, timeout_err
  );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: arbitrates three RTC register requesters (init > user > read,
// with anti-starvation for read) onto a single RTC bus engine. One transaction is
// in flight at a time: IDLE -> START -> WAIT -> ACK.
// Ports:
//   CLK   - clock
//   reset - synchronous, active-high
//   bus   - rtc_bus_arbiter_if.slave (requests, grants/acks, rdata, engine cmd)
// Optional feature: define RTC_ARB_TIMEOUT_EN to abort an engine wait after
// TIMEOUT_CYCLES cycles (timeout_err pulses with ack). Without it WAIT is unbounded
// and timeout_err is tied low.
module rtc_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input logic              CLK,
  input logic              reset,
  rtc_bus_arbiter_if.slave bus
);

  localparam int unsigned SCW = 4;
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  // Elaboration-time parameter range checks
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("rtc_bus_arbiter: STARVE_LIMIT must be 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rtc_bus_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

  state_t         state;
  logic [SCW-1:0] starve_cnt;
  logic           starved;
  logic [2:0]     pick;

`ifdef RTC_ARB_TIMEOUT_EN
  localparam int unsigned WCW = 8;
  localparam logic [WCW-1:0] TMO_MAX = WCW'(TIMEOUT_CYCLES);
  logic [WCW-1:0] wait_cnt;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // Read overtakes user once user has been granted STARVE_LIMIT times in a row
  // while the read was waiting.
  assign starved = (starve_cnt == STARVE_MAX) && bus.req_rd;

  // One-hot winner among the current requests
  always_comb begin
    pick = 3'b000;
    if (bus.req_init)                pick = 3'b001;
    else if (bus.req_us && !starved) pick = 3'b010;
    else if (bus.req_rd)             pick = 3'b100;
  end

  // Arbitration FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      bus.gnt       <= 3'b000;
      bus.ack       <= 3'b000;
      bus.rdata     <= 8'h00;
      bus.eng_start <= 1'b0;
      bus.eng_addr  <= 8'h00;
      bus.eng_wdata <= 8'h00;
      bus.eng_we    <= 1'b0;
      bus.busy      <= 1'b0;
`ifdef RTC_ARB_TIMEOUT_EN
      bus.timeout_err <= 1'b0;
      wait_cnt        <= '0;
`endif
    end else begin
      bus.ack       <= 3'b000;
      bus.eng_start <= 1'b0;
`ifdef RTC_ARB_TIMEOUT_EN
      bus.timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick != 3'b000) begin
            state         <= START;
            bus.gnt       <= pick;
            bus.busy      <= 1'b1;
            bus.eng_start <= 1'b1;
            if (pick[0]) begin
              bus.eng_addr  <= bus.addr_init;
              bus.eng_wdata <= bus.wdata_init;
              bus.eng_we    <= 1'b1;
            end else if (pick[1]) begin
              bus.eng_addr  <= bus.addr_us;
              bus.eng_wdata <= bus.wdata_us;
              bus.eng_we    <= 1'b1;
              if (bus.req_rd && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + SCW'(1);
            end else begin
              // Reads carry no data; eng_wdata keeps its last value
              bus.eng_addr <= bus.addr_rd;
              bus.eng_we   <= 1'b0;
              starve_cnt   <= '0;
            end
          end
        end
        START: begin
          state <= WAIT;
`ifdef RTC_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (bus.eng_done) begin
            state     <= ACK;
            bus.rdata <= bus.eng_rdata;
            bus.ack   <= bus.gnt;
          end
`ifdef RTC_ARB_TIMEOUT_EN
          else if (wait_cnt == TMO_MAX) begin
            // Abort: complete toward the requester but keep the old rdata
            state           <= ACK;
            bus.ack         <= bus.gnt;
            bus.timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
`endif
        end
        ACK: begin
          state    <= IDLE;
          bus.gnt  <= 3'b000;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Self-checking bench for rtc_bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level priority/starvation model.
module tb_rtc_bus_arbiter;

  localparam int unsigned TMO    = 10;
  localparam int unsigned STARVE = 4;

  logic CLK;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  rtc_bus_arbiter_if bus ();

  rtc_bus_arbiter #(
    .TIMEOUT_CYCLES(TMO),
    .STARVE_LIMIT  (STARVE)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.req_init = 1'b0; bus.req_us = 1'b0; bus.req_rd = 1'b0;
    bus.addr_init = 8'h00; bus.addr_us = 8'h00; bus.addr_rd = 8'h00;
    bus.wdata_init = 8'h00; bus.wdata_us = 8'h00;
    bus.eng_done = 1'b0; bus.eng_rdata = 8'h00;
  endtask

  // Leaves the bench at a negedge with the DUT freshly reset
  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge CLK);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", bus.gnt); end
    checks++; if (bus.ack !== 3'b000) begin errors++; $display("FAIL reset_ack got %b exp 000", bus.ack); end
    checks++; if (bus.eng_start !== 1'b0 || bus.eng_we !== 1'b0) begin errors++; $display("FAIL reset_eng got start=%b we=%b exp 0 0", bus.eng_start, bus.eng_we); end
    checks++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_busy got busy=%b tmo=%b exp 0 0", bus.busy, bus.timeout_err); end
    checks++; if (bus.rdata !== 8'h00 || bus.eng_addr !== 8'h00 || bus.eng_wdata !== 8'h00) begin errors++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h exp 00", bus.rdata, bus.eng_addr, bus.eng_wdata); end
  endtask

  // Read with engine completing in cycle 4; ack expected in cycle 5
  task automatic test_read_latency();
    do_reset();
    bus.req_rd = 1'b1; bus.addr_rd = 8'h00;
    @(negedge CLK); // cycle 1
    bus.req_rd = 1'b0;
    checks++; if (bus.eng_start !== 1'b1 || bus.eng_we !== 1'b0 || bus.gnt !== 3'b100) begin errors++; $display("FAIL rd_start got start=%b we=%b gnt=%b exp 1 0 100", bus.eng_start, bus.eng_we, bus.gnt); end
    for (int c = 2; c <= 4; c++) begin
      @(negedge CLK);
      checks++; if (bus.ack !== 3'b000 || bus.eng_start !== 1'b0) begin errors++; $display("FAIL rd_wait cycle %0d got ack=%b start=%b exp 000 0", c, bus.ack, bus.eng_start); end
    end
    bus.eng_done = 1'b1; bus.eng_rdata = 8'h59;
    @(negedge CLK); // cycle 5
    bus.eng_done = 1'b0; bus.eng_rdata = 8'h00;
    checks++; if (bus.ack !== 3'b100 || bus.rdata !== 8'h59) begin errors++; $display("FAIL rd_ack got ack=%b rdata=%h exp 100 59", bus.ack, bus.rdata); end
    @(negedge CLK);
    checks++; if (bus.ack !== 3'b000 || bus.busy !== 1'b0 || bus.gnt !== 3'b000) begin errors++; $display("FAIL rd_done got ack=%b busy=%b gnt=%b exp 000 0 000", bus.ack, bus.busy, bus.gnt); end
  endtask

  // All three requesting: init once, then user until read starves
  task automatic test_starvation();
    logic [2:0] exp_seq [7];
    logic [2:0] g;
    int waited;
    exp_seq = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b010};
    do_reset();
    bus.req_init = 1'b1; bus.req_us = 1'b1; bus.req_rd = 1'b1;
    for (int t = 0; t < 7; t++) begin
      waited = 0;
      do begin
        @(negedge CLK);
        waited++;
        checks++; if (!$onehot0(bus.gnt)) begin errors++; $display("FAIL starve_onehot got gnt=%b exp at most one bit", bus.gnt); end
      end while (bus.eng_start !== 1'b1 && waited < 10);
      g = bus.gnt;
      checks++; if (bus.eng_start !== 1'b1 || g !== exp_seq[t]) begin errors++; $display("FAIL starve_seq[%0d] got start=%b gnt=%b exp 1 %b", t, bus.eng_start, g, exp_seq[t]); end
      @(negedge CLK);
      bus.eng_done = 1'b1; bus.eng_rdata = 8'(t);
      @(negedge CLK); // ack cycle
      bus.eng_done = 1'b0;
      checks++; if (bus.ack !== g) begin errors++; $display("FAIL starve_ack[%0d] got %b exp %b", t, bus.ack, g); end
      if (g === 3'b001) bus.req_init = 1'b0;
      if (t == 6) begin bus.req_us = 1'b0; bus.req_rd = 1'b0; end
    end
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL starve_idle got busy=%b exp 0", bus.busy); end
  endtask

  // User write with request and inputs changing after grant
  task automatic test_drop_after_grant();
    do_reset();
    bus.req_us = 1'b1; bus.addr_us = 8'h21; bus.wdata_us = 8'h45;
    @(negedge CLK); // START
    checks++; if (bus.eng_start !== 1'b1 || bus.eng_we !== 1'b1 || bus.eng_addr !== 8'h21 || bus.eng_wdata !== 8'h45) begin errors++; $display("FAIL drop_start got start=%b we=%b addr=%h wdata=%h exp 1 1 21 45", bus.eng_start, bus.eng_we, bus.eng_addr, bus.eng_wdata); end
    @(negedge CLK); // WAIT
    bus.req_us = 1'b0; bus.addr_us = 8'hA7; bus.wdata_us = 8'h3C;
    repeat (2) begin
      @(negedge CLK);
      checks++; if (bus.eng_we !== 1'b1 || bus.eng_addr !== 8'h21 || bus.eng_wdata !== 8'h45 || bus.gnt !== 3'b010) begin errors++; $display("FAIL drop_hold got we=%b addr=%h wdata=%h gnt=%b exp 1 21 45 010", bus.eng_we, bus.eng_addr, bus.eng_wdata, bus.gnt); end
    end
    bus.eng_done = 1'b1; bus.eng_rdata = 8'h11;
    @(negedge CLK);
    bus.eng_done = 1'b0;
    checks++; if (bus.ack !== 3'b010 || bus.eng_addr !== 8'h21 || bus.eng_wdata !== 8'h45) begin errors++; $display("FAIL drop_ack got ack=%b addr=%h wdata=%h exp 010 21 45", bus.ack, bus.eng_addr, bus.eng_wdata); end
    @(negedge CLK);
    checks++; if (bus.busy !== 1'b0 || bus.ack !== 3'b000) begin errors++; $display("FAIL drop_idle got busy=%b ack=%b exp 0 000", bus.busy, bus.ack); end
  endtask

  // Reset while waiting on the engine
  task automatic test_reset_mid();
    do_reset();
    bus.req_rd = 1'b1; bus.addr_rd = 8'h33;
    @(negedge CLK); // START
    bus.req_rd = 1'b0;
    @(negedge CLK); // WAIT
    checks++; if (bus.busy !== 1'b1 || bus.gnt !== 3'b100) begin errors++; $display("FAIL rstmid_wait got busy=%b gnt=%b exp 1 100", bus.busy, bus.gnt); end
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    checks++; if (bus.gnt !== 3'b000 || bus.ack !== 3'b000 || bus.busy !== 1'b0 || bus.eng_start !== 1'b0) begin errors++; $display("FAIL rstmid_idle got gnt=%b ack=%b busy=%b start=%b exp 000 000 0 0", bus.gnt, bus.ack, bus.busy, bus.eng_start); end
    bus.eng_done = 1'b1; bus.eng_rdata = 8'hEE;
    @(negedge CLK);
    bus.eng_done = 1'b0;
    checks++; if (bus.ack !== 3'b000 || bus.rdata !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_late_done got ack=%b rdata=%h busy=%b exp 000 00 0", bus.ack, bus.rdata, bus.busy); end
    @(negedge CLK);
    checks++; if (bus.ack !== 3'b000 || bus.gnt !== 3'b000) begin errors++; $display("FAIL rstmid_after got ack=%b gnt=%b exp 000 000", bus.ack, bus.gnt); end
  endtask

  // Engine never answers
  task automatic test_timeout();
    do_reset();
    // Seed rdata with a known value first
    bus.req_rd = 1'b1; bus.addr_rd = 8'h05;
    @(negedge CLK);
    bus.req_rd = 1'b0;
    @(negedge CLK);
    bus.eng_done = 1'b1; bus.eng_rdata = 8'h6B;
    @(negedge CLK);
    bus.eng_done = 1'b0;
    @(negedge CLK); // IDLE
    bus.req_rd = 1'b1;
    @(negedge CLK); // START (cycle 1), WAIT entered at the next edge
    bus.req_rd = 1'b0;
`ifdef RTC_ARB_TIMEOUT_EN
    for (int c = 2; c <= int'(TMO) + 2; c++) begin
      @(negedge CLK);
      checks++; if (bus.ack !== 3'b000 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early cycle %0d got ack=%b tmo=%b exp 000 0", c, bus.ack, bus.timeout_err); end
    end
    @(negedge CLK);
    checks++; if (bus.ack !== 3'b100 || bus.timeout_err !== 1'b1 || bus.rdata !== 8'h6B) begin errors++; $display("FAIL tmo_pulse got ack=%b tmo=%b rdata=%h exp 100 1 6b", bus.ack, bus.timeout_err, bus.rdata); end
    @(negedge CLK);
    checks++; if (bus.ack !== 3'b000 || bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got ack=%b tmo=%b busy=%b exp 000 0 0", bus.ack, bus.timeout_err, bus.busy); end
`else
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      checks++; if (bus.busy !== 1'b1 || bus.ack !== 3'b000 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL notmo_hold cycle %0d got busy=%b ack=%b tmo=%b exp 1 000 0", c, bus.busy, bus.ack, bus.timeout_err); end
    end
    checks++; if (bus.rdata !== 8'h6B) begin errors++; $display("FAIL notmo_rdata got %h exp 6b", bus.rdata); end
`endif
  endtask

  // Request held through ack re-arbitrates; eng_start pulses 4 cycles apart
  task automatic test_back_to_back();
    do_reset();
    bus.req_us = 1'b1; bus.addr_us = 8'h40; bus.wdata_us = 8'h01;
    @(negedge CLK);
    checks++; if (bus.eng_start !== 1'b1) begin errors++; $display("FAIL b2b_first got start=%b exp 1", bus.eng_start); end
    @(negedge CLK);
    bus.eng_done = 1'b1;
    checks++; if (bus.eng_start !== 1'b0) begin errors++; $display("FAIL b2b_gap1 got start=%b exp 0", bus.eng_start); end
    @(negedge CLK);
    bus.eng_done = 1'b0;
    checks++; if (bus.eng_start !== 1'b0 || bus.ack !== 3'b010) begin errors++; $display("FAIL b2b_ack got start=%b ack=%b exp 0 010", bus.eng_start, bus.ack); end
    @(negedge CLK);
    checks++; if (bus.eng_start !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got start=%b busy=%b exp 0 0", bus.eng_start, bus.busy); end
    @(negedge CLK);
    bus.req_us = 1'b0;
    checks++; if (bus.eng_start !== 1'b1 || bus.gnt !== 3'b010) begin errors++; $display("FAIL b2b_second got start=%b gnt=%b exp 1 010", bus.eng_start, bus.gnt); end
    @(negedge CLK);
    bus.eng_done = 1'b1;
    @(negedge CLK);
    bus.eng_done = 1'b0;
    @(negedge CLK);
  endtask

  // Randomized transactions against a transaction-level model
  task automatic test_random();
    int         starve;
    logic [7:0] last_rdata;
    logic [2:0] r;
    logic [2:0] exp_g;
    logic [7:0] exp_addr;
    logic [7:0] exp_wdata;
    logic       exp_we;
    logic [7:0] val;
    int         lat;
    do_reset();
    starve = 0;
    last_rdata = 8'h00;
    for (int it = 0; it < 80; it++) begin
      @(negedge CLK);
      r = 3'($urandom_range(0, 7));
      bus.req_init = r[0]; bus.req_us = r[1]; bus.req_rd = r[2];
      bus.addr_init = 8'($urandom); bus.addr_us = 8'($urandom); bus.addr_rd = 8'($urandom);
      bus.wdata_init = 8'($urandom); bus.wdata_us = 8'($urandom);
      exp_addr = 8'h00; exp_wdata = 8'h00; exp_we = 1'b0;
      if (r[0]) begin
        exp_g = 3'b001; exp_addr = bus.addr_init; exp_wdata = bus.wdata_init; exp_we = 1'b1;
      end else if (r[1] && !(starve == int'(STARVE) && r[2])) begin
        exp_g = 3'b010; exp_addr = bus.addr_us; exp_wdata = bus.wdata_us; exp_we = 1'b1;
        if (r[2] && starve < int'(STARVE)) starve++;
      end else if (r[2]) begin
        exp_g = 3'b100; exp_addr = bus.addr_rd; starve = 0;
      end else begin
        exp_g = 3'b000;
      end
      @(negedge CLK);
      bus.req_init = 1'b0; bus.req_us = 1'b0; bus.req_rd = 1'b0;
      if (exp_g == 3'b000) begin
        checks++; if (bus.gnt !== 3'b000 || bus.busy !== 1'b0 || bus.eng_start !== 1'b0) begin errors++; $display("FAIL rnd_noreq it %0d got gnt=%b busy=%b start=%b exp 000 0 0", it, bus.gnt, bus.busy, bus.eng_start); end
        continue;
      end
      checks++; if (bus.gnt !== exp_g || bus.eng_start !== 1'b1 || bus.busy !== 1'b1 || bus.ack !== 3'b000) begin errors++; $display("FAIL rnd_grant it %0d got gnt=%b start=%b busy=%b ack=%b exp %b 1 1 000", it, bus.gnt, bus.eng_start, bus.busy, bus.ack, exp_g); end
      checks++; if (bus.eng_addr !== exp_addr || bus.eng_we !== exp_we || (exp_we && bus.eng_wdata !== exp_wdata)) begin errors++; $display("FAIL rnd_cmd it %0d got addr=%h we=%b wdata=%h exp %h %b %h", it, bus.eng_addr, bus.eng_we, bus.eng_wdata, exp_addr, exp_we, exp_wdata); end
      // A stray done during START must be ignored
      if ($urandom_range(0, 1) == 1) begin bus.eng_done = 1'b1; bus.eng_rdata = 8'($urandom); end
      @(negedge CLK);
      bus.eng_done = 1'b0;
      checks++; if (bus.eng_start !== 1'b0 || bus.ack !== 3'b000 || bus.rdata !== last_rdata) begin errors++; $display("FAIL rnd_wait it %0d got start=%b ack=%b rdata=%h exp 0 000 %h", it, bus.eng_start, bus.ack, bus.rdata, last_rdata); end
      lat = $urandom_range(0, 4);
      for (int j = 0; j < lat; j++) begin
        @(negedge CLK);
        checks++; if (bus.ack !== 3'b000 || bus.gnt !== exp_g) begin errors++; $display("FAIL rnd_hold it %0d got ack=%b gnt=%b exp 000 %b", it, bus.ack, bus.gnt, exp_g); end
      end
      val = 8'($urandom);
      bus.eng_done = 1'b1; bus.eng_rdata = val;
      @(negedge CLK);
      bus.eng_done = 1'b0;
      checks++; if (bus.ack !== exp_g || bus.rdata !== val || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rnd_ack it %0d got ack=%b rdata=%h tmo=%b exp %b %h 0", it, bus.ack, bus.rdata, bus.timeout_err, exp_g, val); end
      last_rdata = val;
      @(negedge CLK);
      checks++; if (bus.ack !== 3'b000 || bus.gnt !== 3'b000 || bus.busy !== 1'b0) begin errors++; $display("FAIL rnd_idle it %0d got ack=%b gnt=%b busy=%b exp 000 000 0", it, bus.ack, bus.gnt, bus.busy); end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_read_latency();
    test_starvation();
    test_drop_after_grant();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_arbiter.md
RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, engine-wait limit in CLK cycles (range 1..255); used only when RTC_ARB_TIMEOUT_EN is defined.
REQ-002 Parameter: STARVE_LIMIT, default 4, consecutive user grants allowed while a read is pending (range 1..15).
REQ-003 reset is an input, 1 bit, synchronous, active-high; CLK is an input, 1 bit, clock.
REQ-004 req_init, req_us and req_rd are inputs, 1 bit each, level requests from initialization, user control and periodic read.
REQ-005 addr_init, addr_us and addr_rd are inputs, 8 bits each, RTC register address per requester.
REQ-006 wdata_init and wdata_us are inputs, 8 bits each, write data; the read requester always reads.
REQ-007 gnt is an output, 3 bits, one-hot grant: bit0 init, bit1 user, bit2 read.
REQ-008 ack is an output, 3 bits, one-cycle completion pulse per requester, same bit order as gnt.
REQ-009 rdata is an output, 8 bits, data captured from the engine at completion.
REQ-010 eng_start is an output, 1 bit; eng_addr is an output, 8 bits; eng_wdata is an output, 8 bits; eng_we is an output, 1 bit. Together these form the transaction command to the RTC bus engine.
REQ-011 eng_done is an input, 1 bit, one-cycle completion pulse; eng_rdata is an input, 8 bits, valid with eng_done.
REQ-012 busy is an output, 1 bit, high in every state except IDLE.
REQ-013 timeout_err is an output, 1 bit, one-cycle abort pulse.

Function
REQ-014 The FSM SHALL have the states IDLE, START, WAIT and ACK; all outputs SHALL be registered.
REQ-015 In IDLE with any request high at edge k, the block SHALL latch the winner's address, data and we (init and user: we=1; read: we=0), set the winner's gnt bit and enter START at edge k.
REQ-016 Priority SHALL be init > user > read, except that once starve_cnt equals STARVE_LIMIT and req_rd is high, read SHALL beat user; init always wins.
REQ-017 starve_cnt SHALL increment on each user grant made while req_rd is high, clear on any read grant, and saturate at STARVE_LIMIT.
REQ-018 START SHALL drive eng_start=1 for exactly one cycle with a stable eng_addr, eng_wdata and eng_we, then enter WAIT.
REQ-019 eng_addr, eng_wdata and eng_we SHALL hold their values from START until ACK completes.
REQ-020 In WAIT, eng_done=1 SHALL latch eng_rdata into rdata and enter ACK; rdata SHALL otherwise hold its value.
REQ-021 ACK SHALL pulse the winner's ack bit for one cycle, clear gnt and return to IDLE.
REQ-022 Latency: eng_start SHALL be high in cycle k+1 after a request is sampled at edge k; ack SHALL be high in cycle d+1 after eng_done is sampled at edge d.
REQ-023 Minimum spacing between consecutive eng_start pulses SHALL be 4 cycles.
REQ-024 A request dropped after grant SHALL NOT abort the transaction; ack is still pulsed.
REQ-025 A request still high during its ack cycle SHALL be treated as a new request in the following IDLE.
REQ-026 eng_done received outside WAIT SHALL be ignored.
REQ-027 Simultaneous requests SHALL produce exactly one grant; gnt SHALL never have more than one bit set.

Reset
REQ-028 On reset the block SHALL enter IDLE and clear gnt, ack, eng_start, eng_we, busy, timeout_err, starve_cnt and the wait counter.
REQ-029 On reset rdata, eng_addr and eng_wdata SHALL be 8'h00.
REQ-030 Reset mid-transaction SHALL abandon the transaction without an ack pulse.

Configuration
REQ-031 With RTC_ARB_TIMEOUT_EN defined, a wait counter SHALL count cycles spent in WAIT. On reaching TIMEOUT_CYCLES without eng_done it SHALL pulse timeout_err together with ack, leave rdata unchanged, and enter IDLE through ACK.
REQ-032 Without RTC_ARB_TIMEOUT_EN, WAIT SHALL last indefinitely, timeout_err SHALL be constant 0, and no wait counter SHALL exist.

Verification
REQ-033 Drive req_rd=1 with addr_rd=8'h00 and eng_done after 3 cycles with eng_rdata=8'h59: expect eng_start in cycle 1, eng_we=0, ack=3'b100 in cycle 5, rdata=8'h59.
REQ-034 Drive req_init, req_us and req_rd high together: expect gnt sequence 001, 010, 010, 010, 010, 100, 010 with STARVE_LIMIT=4, and never two gnt bits set.
REQ-035 Drive req_us with addr_us=8'h21 and wdata_us=8'h45, then drop req_us during WAIT: expect eng_we=1, eng_addr=8'h21, eng_wdata=8'h45 held stable, and ack=3'b010 still issued.
REQ-036 Assert reset in WAIT: expect IDLE next cycle, gnt=0, no ack, and a later eng_done ignored.
REQ-037 With RTC_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=10, never return eng_done: expect timeout_err and ack pulsed together 11 cycles after WAIT entry and rdata unchanged; without the macro, expect busy held high.
